multicycle_control_fsm: RTL

Multicycle successor to the single-cycle main/ALU decoder in the CPU control unit. It sequences each ARM-subset instruction through fetch, decode, execute, memory and writeback states, and drives all datapath enables and muxes per state. It adds three things over the single-cycle decoder:
- a memory wait handshake;
- a wider ALU command set (EOR, MOV, CMP, TST);
- an illegal-instruction report.

It sits between the instruction register and the conditional-logic block, which gates RegW/MemW/PCS by condition flags.

---
 rtl/cpu_ctrl_pkg.sv | 99 +++++++++
 rtl/alu_cmd_decode.sv | 45 ++++
 rtl/multicycle_control_fsm.sv | 114 +++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and codes for the multicycle CPU control unit
// Purpose: state encoding, ALU command codes, datapath mux select codes and the
// per-state Moore control row used by multicycle_control_fsm.
// Ports: none (package).
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_ORR = 3'd3,
    ALU_EOR = 3'd4,
    ALU_MOV = 3'd5
  } alu_cmd_t;

  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Moore control row; 'fetch' marks the state whose IRWrite/NextPC are
  // qualified by mem_ready outside the register.
  typedef struct packed {
    logic       fetch;
    logic       reg_w;
    logic       mem_w;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       branch;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch      = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
      end
      DECODE: begin
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
      end
      MEMADR: c.alu_src_b = SRCB_IMM;
      MEMRD:  c.adr_src   = 1'b1;
      MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_w      = 1'b1;
      end
      MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      EXECR: begin
        c.alu_src_b = SRCB_REG;
        c.alu_op    = 1'b1;
      end
      EXECI: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = 1'b1;
      end
      ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_w      = 1'b1;
      end
      BRANCH: begin
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALU;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_cmd_decode.sv
// rtl/alu_cmd_decode.sv - data-processing cmd field to ALU command decoder
// Purpose: combinational decode of Funct[4:1] (cmd) and Funct[0] (S bit).
// Ports: cmd_i cmd field, s_i S bit; alu_control_o ALU command (zero-extended),
//        no_write_o flag-only instruction, flag_w_o {NZ write, CV write},
//        valid_o cmd is a supported encoding.
module alu_cmd_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [3:0]            cmd_i,
  input  logic                  s_i,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic                  no_write_o,
  output logic [1:0]            flag_w_o,
  output logic                  valid_o
);

  alu_cmd_t cmd;
  logic     arith;

  always_comb begin
    cmd        = ALU_ADD;
    no_write_o = 1'b0;
    arith      = 1'b0;
    valid_o    = 1'b1;
    case (cmd_i)
      4'b0100: begin cmd = ALU_ADD; arith = 1'b1; end
      4'b0010: begin cmd = ALU_SUB; arith = 1'b1; end
      4'b0000: cmd = ALU_AND;
      4'b1100: cmd = ALU_ORR;
      4'b0001: cmd = ALU_EOR;
      4'b1101: cmd = ALU_MOV;
      // CMP / TST reuse SUB / AND but only update flags
      4'b1010: begin cmd = ALU_SUB; arith = 1'b1; no_write_o = 1'b1; end
      4'b1000: begin cmd = ALU_AND; no_write_o = 1'b1; end
      default: valid_o = 1'b0;
    endcase
    flag_w_o[1] = s_i | no_write_o;
    flag_w_o[0] = flag_w_o[1] & arith;
  end

  assign alu_control_o = ALU_CTRL_W'(cmd);

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle main controller for the ARM-subset CPU
// Purpose: sequences each instruction through fetch/decode/execute/memory/
// writeback and drives datapath enables and mux selects per state.
// Ports: clk, reset (sync, active-high); Op/Funct/Rd instruction fields;
//        mem_ready memory handshake; PCS/NextPC/RegW/MemW/IRWrite enables;
//        AdrSrc/ALUSrcA/ALUSrcB/ResultSrc/ImmSrc/RegSrc mux selects;
//        ALUControl/FlagW/NoWrite ALU decode; illegal pulse; state for debug.
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter bit MEM_WAIT   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic                  mem_ready,
  output logic                  PCS,
  output logic                  NextPC,
  output logic                  RegW,
  output logic                  MemW,
  output logic                  IRWrite,
  output logic                  AdrSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [1:0]            FlagW,
  output logic                  NoWrite,
  output logic                  illegal,
  output logic [3:0]            state
);

  state_t                  state_q, state_d;
  ctrl_t                   ctrl_q;
  logic                    illegal_q;
  logic                    ready;
  logic [ALU_CTRL_W-1:0]   dec_ctrl;
  logic                    dec_nw;
  logic [1:0]              dec_flag;
  logic                    dec_valid;
  logic                    decode_illegal;

  // Without wait support every memory access completes in its first cycle.
  assign ready = MEM_WAIT ? mem_ready : 1'b1;

  alu_cmd_decode #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_cmd_decode (
    .cmd_i         (Funct[4:1]),
    .s_i           (Funct[0]),
    .alu_control_o (dec_ctrl),
    .no_write_o    (dec_nw),
    .flag_w_o      (dec_flag),
    .valid_o       (dec_valid)
  );

  assign decode_illegal = (Op == 2'b11) | ((Op == 2'b00) & ~dec_valid);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (ready) state_d = DECODE;
      DECODE: begin
        if (decode_illegal)     state_d = FETCH;
        else if (Op == 2'b00)   state_d = Funct[5] ? EXECI : EXECR;
        else if (Op == 2'b01)   state_d = MEMADR;
        else                    state_d = BRANCH;
      end
      MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  if (ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (ready) state_d = FETCH;
      EXECR,
      EXECI:  state_d = dec_nw ? FETCH : ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Control row is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      ctrl_q    <= state_ctrl(FETCH);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= state_ctrl(state_d);
      illegal_q <= (state_q == DECODE) & decode_illegal;
    end
  end

  assign IRWrite    = ctrl_q.fetch & ready;
  assign NextPC     = ctrl_q.fetch & ready;
  assign RegW       = ctrl_q.reg_w;
  assign MemW       = ctrl_q.mem_w;
  assign AdrSrc     = ctrl_q.adr_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ResultSrc  = ctrl_q.result_src;
  assign PCS        = ((Rd == 4'hF) & ctrl_q.reg_w) | ctrl_q.branch;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b10, (Op == 2'b01) & ~Funct[0]};
  assign ALUControl = ctrl_q.alu_op ? dec_ctrl : '0;
  assign FlagW      = ctrl_q.alu_op ? dec_flag : 2'b00;
  assign NoWrite    = ctrl_q.alu_op & dec_nw;
  assign illegal    = illegal_q;
  assign state      = state_q;

endmodule
